// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared types and helpers for the RO PUF evaluation sequencer
package ro_puf_pkg;

   localparam int CNT_W_DEFAULT = 16;
   localparam int SEL_W_DEFAULT = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_HOLD,
      ST_COMPARE,
      ST_DONE
   } ro_puf_state_t;

   // Clocks spent on one response bit: CLEAR + RUN window + HOLD + COMPARE.
   function automatic int bit_period(input int window_cycles, input int sync_cycles);
      return window_cycles + sync_cycles + 2;
   endfunction

endpackage

// File: rtl/ro_puf_win_timer.sv
// rtl/ro_puf_win_timer.sv - loadable down-counter timing the RUN and HOLD intervals
module ro_puf_win_timer #(
   parameter int TW = 9
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   output logic [TW-1:0] value_o,
   output logic          expired_o
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o   = cnt_q;
   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ro_puf_eval_ctrl.sv
// rtl/ro_puf_eval_ctrl.sv - RO PUF challenge/response sequencer; PUF_MARGIN_EN adds per-bit reliability flags
module ro_puf_eval_ctrl
   import ro_puf_pkg::*;
#(
   parameter int CNT_W         = CNT_W_DEFAULT,
   parameter int SEL_W         = SEL_W_DEFAULT,
   parameter int RESP_BITS     = 8,
   parameter int WINDOW_CYCLES = 256,
   parameter int SYNC_CYCLES   = 2,
   parameter int MARGIN        = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [2*SEL_W-1:0]   challenge_i,
   input  logic [CNT_W-1:0]     count_a_i,
   input  logic [CNT_W-1:0]     count_b_i,
   output logic                 ro_en_o,
   output logic                 cnt_clr_o,
   output logic [SEL_W-1:0]     sel_a_o,
   output logic [SEL_W-1:0]     sel_b_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [RESP_BITS-1:0] resp_o,
   output logic                 resp_valid_o,
   output logic [RESP_BITS-1:0] resp_rel_o
);

   localparam int TMR_MAX = (WINDOW_CYCLES > SYNC_CYCLES) ? WINDOW_CYCLES : SYNC_CYCLES;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

   ro_puf_state_t        state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [SEL_W-1:0]     sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic [RESP_BITS-1:0] resp_q, resp_d;
   logic                 valid_q, valid_d;
   logic                 rel_bit;

   logic                 tmr_load, tmr_expired;
   logic [TW-1:0]        tmr_val;
   logic [TW-1:0]        unused_tmr_value;

   ro_puf_win_timer #(.TW(TW)) u_win_timer (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .value_o    (unused_tmr_value),
      .expired_o  (tmr_expired)
   );

`ifdef PUF_MARGIN_EN
   localparam logic [CNT_W:0] MARGIN_V = (CNT_W+1)'(MARGIN);
   logic [RESP_BITS-1:0] rel_q, rel_d;
   logic [CNT_W:0]       diff;

   // Widened by one bit so the magnitude never wraps.
   always_comb begin
      if (count_a_i >= count_b_i) begin
         diff = {1'b0, count_a_i} - {1'b0, count_b_i};
      end else begin
         diff = {1'b0, count_b_i} - {1'b0, count_a_i};
      end
      rel_bit = (diff >= MARGIN_V);
   end
`else
   localparam int unused_margin = MARGIN;
   assign rel_bit = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      sel_a_d   = sel_a_q;
      sel_b_d   = sel_b_q;
      resp_d    = resp_q;
      valid_d   = valid_q;
`ifdef PUF_MARGIN_EN
      rel_d     = rel_q;
`endif
      tmr_load  = 1'b0;
      tmr_val   = '0;
      ro_en_o   = 1'b0;
      cnt_clr_o = 1'b0;
      done_o    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sel_a_d = challenge_i[SEL_W-1:0];
               sel_b_d = challenge_i[2*SEL_W-1:SEL_W];
               resp_d  = '0;
               valid_d = 1'b0;
               idx_d   = '0;
`ifdef PUF_MARGIN_EN
               rel_d   = '0;
`endif
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            cnt_clr_o = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = TW'(WINDOW_CYCLES - 1);
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            ro_en_o = 1'b1;
            if (tmr_expired) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(SYNC_CYCLES - 1);
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_expired) begin
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            resp_d[idx_q] = (count_a_i > count_b_i);
`ifdef PUF_MARGIN_EN
            rel_d[idx_q]  = rel_bit;
`endif
            if (idx_q != LAST_IDX) begin
               idx_d   = idx_q + 1'b1;
               sel_a_d = sel_a_q + 1'b1;
               sel_b_d = sel_b_q + 1'b1;
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort freezes every register except the state, which drops to IDLE.
      if (abort_i) begin
         state_d = ST_IDLE;
         idx_d   = idx_q;
         sel_a_d = sel_a_q;
         sel_b_d = sel_b_q;
         resp_d  = resp_q;
         valid_d = valid_q;
`ifdef PUF_MARGIN_EN
         rel_d   = rel_q;
`endif
         done_o  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         sel_a_q <= '0;
         sel_b_q <= '0;
         resp_q  <= '0;
         valid_q <= 1'b0;
`ifdef PUF_MARGIN_EN
         rel_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         resp_q  <= resp_d;
         valid_q <= valid_d;
`ifdef PUF_MARGIN_EN
         rel_q   <= rel_d;
`endif
      end
   end

   assign sel_a_o      = sel_a_q;
   assign sel_b_o      = sel_b_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign resp_o       = resp_q;
   assign resp_valid_o = valid_q;
`ifdef PUF_MARGIN_EN
   assign resp_rel_o   = rel_q;
`else
   assign resp_rel_o   = '1;
`endif

endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// tb/tb_ro_puf_eval_ctrl.sv - self-checking bench for ro_puf_eval_ctrl
module tb_ro_puf_eval_ctrl;
   import ro_puf_pkg::*;

   localparam int WIN     = 8;
   localparam int SYNC    = 2;
   localparam int NB      = 4;
   localparam int DONE_AT = NB * bit_period(WIN, SYNC) + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  challenge = '0;
   logic [15:0] count_a, count_b;
   logic        ro_en, cnt_clr, busy, done, resp_valid;
   logic [3:0]  sel_a, sel_b, resp, resp_rel;

   int total = 0;
   int bad   = 0;
   int cmode = 0;

   logic [3:0] resp_sb[$];
   logic [7:0] sel_sb[$];

   typedef struct {
      logic [7:0] ch;
      int         mode;
      logic [3:0] exp_resp;
      bit         poke;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   ro_puf_eval_ctrl #(
      .CNT_W(16), .SEL_W(4), .RESP_BITS(NB),
      .WINDOW_CYCLES(WIN), .SYNC_CYCLES(SYNC), .MARGIN(4)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .challenge_i  (challenge),
      .count_a_i    (count_a),
      .count_b_i    (count_b),
      .ro_en_o      (ro_en),
      .cnt_clr_o    (cnt_clr),
      .sel_a_o      (sel_a),
      .sel_b_o      (sel_b),
      .busy_o       (busy),
      .done_o       (done),
      .resp_o       (resp),
      .resp_valid_o (resp_valid),
      .resp_rel_o   (resp_rel)
   );

   // Counter model: mode 0 favours bank A on odd sel_a, 1 ties, 2/3 give small/large margins.
   always_comb begin
      case (cmode)
         1:       begin count_a = 16'd200; count_b = 16'd200; end
         2:       begin count_a = 16'd102; count_b = 16'd100; end
         3:       begin count_a = 16'd110; count_b = 16'd100; end
         default: begin
            if (sel_a[0]) begin count_a = 16'd100; count_b = 16'd50;  end
            else          begin count_a = 16'd50;  count_b = 16'd100; end
         end
      endcase
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_eval(input logic [7:0] ch, input int mode, input logic [3:0] exp, input bit poke);
      logic [3:0] ea, eb, er;
      logic [7:0] pair;
      int run, clrs, c;
      bit seen, prev_clr;
      cmode     = mode;
      challenge = ch;
      for (int i = 0; i < NB; i++) begin
         ea = ch[3:0] + 4'(i);
         eb = ch[7:4] + 4'(i);
         sel_sb.push_back({eb, ea});
      end
      resp_sb.push_back(exp);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      run = 0; clrs = 0; seen = 1'b0; prev_clr = 1'b0; c = 1;
      while (!seen && c <= DONE_AT + 10) begin
         if (cnt_clr) begin
            clrs++;
            chk("clr_overlap_ro_en", int'(ro_en), 0);
            chk("clr_width", int'(prev_clr), 0);
            if (sel_sb.size() != 0) begin
               pair = sel_sb.pop_front();
               chk("sel_a", int'(sel_a), int'(pair[3:0]));
               chk("sel_b", int'(sel_b), int'(pair[7:4]));
            end else begin
               chk("clr_extra", clrs, NB);
            end
         end
         prev_clr = cnt_clr;
         if (ro_en) begin
            run++;
         end else if (run != 0) begin
            chk("ro_en_len", run, WIN);
            run = 0;
         end
         if (done) begin
            seen = 1'b1;
            chk("done_cycle", c, DONE_AT);
            er = resp_sb.pop_front();
            chk("resp", int'(resp), int'(er));
         end
         start = (poke && c == 20);
         if (!seen) begin
            @(negedge clk);
            c++;
         end
      end
      start = 1'b0;
      chk("done_seen", int'(seen), 1);
      chk("clr_count", clrs, NB);
      @(negedge clk);
      chk("resp_valid", int'(resp_valid), 1);
      chk("busy_after", int'(busy), 0);
      chk("resp_hold", int'(resp), int'(exp));
      resp_sb.delete();
      sel_sb.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ro_en"}, int'(ro_en), 0);
      chk({tag, "_cnt_clr"}, int'(cnt_clr), 0);
      chk({tag, "_sel_a"}, int'(sel_a), 0);
      chk({tag, "_sel_b"}, int'(sel_b), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_resp"}, int'(resp), 0);
      chk({tag, "_resp_valid"}, int'(resp_valid), 0);
`ifdef PUF_MARGIN_EN
      chk({tag, "_resp_rel"}, int'(resp_rel), 0);
`else
      chk({tag, "_resp_rel"}, int'(resp_rel), 15);
`endif
   endtask

   initial begin
      int dones;
      vecs[0] = '{ch: 8'h31, mode: 0, exp_resp: 4'b0101, poke: 1'b0};
      vecs[1] = '{ch: 8'hFF, mode: 1, exp_resp: 4'b0000, poke: 1'b1};
      vecs[2] = '{ch: 8'h52, mode: 0, exp_resp: 4'b1010, poke: 1'b0};
      vecs[3] = '{ch: 8'h0E, mode: 0, exp_resp: 4'b1010, poke: 1'b1};

      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("post_rst");

      for (int i = 0; i < 4; i++) begin
         run_eval(vecs[i].ch, vecs[i].mode, vecs[i].exp_resp, vecs[i].poke);
      end

      // Abort in the third RUN window (cycles 26..33 after accept).
      cmode = 0; challenge = 8'h31;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (27) @(negedge clk);
      chk("abort_pre_ro_en", int'(ro_en), 1);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_ro_en", int'(ro_en), 0);
      chk("abort_cnt_clr", int'(cnt_clr), 0);
      chk("abort_partial_resp", int'(resp), 1);
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("abort_no_done", dones, 0);
      chk("abort_resp_valid", int'(resp_valid), 0);

      run_eval(8'h31, 0, 4'b0101, 1'b0);

      // start and abort together in IDLE: nothing is loaded.
      challenge = 8'h77;
      start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      chk("sa_busy", int'(busy), 0);
      chk("sa_sel_a", int'(sel_a), 4);
      chk("sa_sel_b", int'(sel_b), 6);
      chk("sa_resp_valid", int'(resp_valid), 1);
      @(negedge clk);
      chk("sa_busy_later", int'(busy), 0);

      // Asynchronous reset in the first RUN window.
      challenge = 8'h31;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      chk("arst_pre_ro_en", int'(ro_en), 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("arst");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("arst_idle", int'(busy), 0);

`ifdef PUF_MARGIN_EN
      run_eval(8'h00, 2, 4'hF, 1'b0);
      chk("rel_small", int'(resp_rel), 0);
      run_eval(8'h00, 3, 4'hF, 1'b0);
      chk("rel_large", int'(resp_rel), 15);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
